cmn_regfile_wr_sched: RTL and testbench
=======================================

# cmn_regfile_wr_sched

Write-port scheduler for a 1r1w register file. After reset it sweeps every entry to a known value, then shares the single write port between two val/rdy write requesters using round-robin arbitration. It also forwards the in-flight registered write to the read port, so reads see the newest data. It sits between producer units and the register-file instance, driving that instance's write port and read address.

## Interface
- p_data_nbits, 32: entry width.
- p_num_entries, 32: number of entries; must be at least 2.
- p_init_value, 0: value written to every entry during init, and returned by reads while init runs.
- c_addr_nbits, $clog2(p_num_entries): local, not set externally.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low (0 = in reset).
- req0_val / req1_val  in  1  write request valid.
- req0_rdy / req1_rdy  out  1  request accepted when val && rdy at a rising edge.
- req0_addr / req1_addr  in  c_addr_nbits  target entry.
- req0_data / req1_data  in  p_data_nbits  write data.
- rf_write_en  out  1  registered; drives the register file's write_en.
- rf_write_addr  out  c_addr_nbits  registered.
- rf_write_data  out  p_data_nbits  registered.
- read_addr  in  c_addr_nbits  consumer read address.
- rf_read_addr  out  c_addr_nbits  equals read_addr (combinational).
- rf_read_data  in  p_data_nbits  combinational read data from the register file.
- read_data  out  p_data_nbits  forwarded read result.
- init_done  out  1  high once the init sweep is complete.

## Operation
- FSM has two states, INIT and RUN. Reset puts the FSM in INIT, sets the sweep counter to 0 and sets prio to 0.
- INIT:
  - Each cycle registers a write of p_init_value to the address held in the counter, then increments the counter.
  - After the write to address p_num_entries-1 is registered, the next state is RUN.
  - req0_rdy and req1_rdy are 0 throughout INIT.
- RUN, arbitration (rdy is a combinational function of val and prio):
  - Only one val high: that requester's rdy = 1.
  - Both val high: rdy goes to requester `prio` only.
  - Neither val high: both rdy = 0.
- RUN, prio update: on every transfer, prio becomes the index of the requester that was not granted. With no transfer, prio holds.
- RUN, write port:
  - On a transfer, the next cycle's rf_write_en/addr/data = 1 / granted addr / granted data.
  - With no transfer, rf_write_en = 0 next cycle; addr and data hold their values.
- Out-of-range address (addr >= p_num_entries, possible only when p_num_entries is not a power of 2): the request is still accepted (rdy follows the normal rules) but dropped. rf_write_en stays 0 and prio still updates.
- Read forwarding:
  - INIT: read_data = p_init_value.
  - RUN, rf_write_en && rf_write_addr == read_addr: read_data = rf_write_data.
  - Otherwise read_data = rf_read_data.

## Timing
- Reset values, applied asynchronously:
  - rf_write_en = 0, rf_write_addr = 0, rf_write_data = 0.
  - init_done = 0; req0_rdy and req1_rdy = 0.
- Let edge 1 be the first rising edge after reset deasserts.
  - Edges 1..N (N = p_num_entries) register init writes to addresses 0..N-1.
  - After edge N, state = RUN and init_done = 1. This is the same cycle in which rf_write_en = 1 with addr N-1.
  - rdy can assert in that same cycle.
- Write latency is 1 cycle: a transfer at edge k puts the write on the rf port during cycle k..k+1, and the register file commits it at edge k+1.
- Sustained throughput is one write per cycle, including back-to-back transfers from the same requester.
- A request with val high and rdy low must hold val, addr and data stable until the transfer completes.
- Reset asserted mid-operation: any write pending on the rf port is aborted immediately, all outputs return to reset values, and the full INIT sweep repeats after release.
- init_done stays 1 from entering RUN until the next reset.

## Test plan
- Init sweep (p_num_entries = 4, p_init_value = 8'hA5): release reset; expect rf_write_en = 1 with addr 0,1,2,3 on edges 1–4, data A5 each time; init_done rises after edge 4; no rdy before then.
- Round-robin contention: in RUN, hold both val high (req0 addr 1 data 11, req1 addr 2 data 22) for 4 cycles.
  - Expect grants 0,1,0,1.
  - Expect rf_write_* sequence (1,11), (2,22), (1,11), (2,22), each one cycle after its grant.
- Lone requester: req1_val held for 3 cycles with req0 idle.
  - Expect 3 consecutive transfers.
  - Expect prio = 0 afterwards: a next simultaneous request goes to req0.
- Forwarding: a transfer writes addr 3 = 0x1234 while read_addr = 3.
  - In the cycle rf_write_en is high, expect read_data = 0x1234 whatever rf_read_data is.
  - Next cycle, expect read_data = rf_read_data.
- Reset mid-stream: assert reset while rf_write_en = 1.
  - Expect rf_write_en = 0 and init_done = 0 immediately, with no clock edge needed.
  - After release, expect the INIT sweep to restart from address 0.
- Out-of-range address (p_num_entries = 5): req0 addr 6.
  - Expect req0_rdy = 1, then rf_write_en = 0 next cycle.
  - Expect prio to flip to 1.

Source files
------------

// File: rtl/cmn_regfile_wr_sched.sv
// Write-port scheduler for a 1r1w register file: init sweep, then round-robin
// sharing of the write port between two val/rdy requesters, with read forwarding.
module cmn_regfile_wr_sched #(
  parameter int unsigned                p_data_nbits  = 32,
  parameter int unsigned                p_num_entries = 32,
  parameter logic [p_data_nbits-1:0]    p_init_value  = '0,
  localparam int unsigned               c_addr_nbits  = $clog2(p_num_entries)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req0_val,
  output logic                    req0_rdy,
  input  logic [c_addr_nbits-1:0] req0_addr,
  input  logic [p_data_nbits-1:0] req0_data,
  input  logic                    req1_val,
  output logic                    req1_rdy,
  input  logic [c_addr_nbits-1:0] req1_addr,
  input  logic [p_data_nbits-1:0] req1_data,
  output logic                    rf_write_en,
  output logic [c_addr_nbits-1:0] rf_write_addr,
  output logic [p_data_nbits-1:0] rf_write_data,
  input  logic [c_addr_nbits-1:0] read_addr,
  output logic [c_addr_nbits-1:0] rf_read_addr,
  input  logic [p_data_nbits-1:0] rf_read_data,
  output logic [p_data_nbits-1:0] read_data,
  output logic                    init_done
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  localparam logic [c_addr_nbits:0]   c_num  = (c_addr_nbits+1)'(p_num_entries);
  localparam logic [c_addr_nbits-1:0] c_last = c_addr_nbits'(p_num_entries - 1);

  state_t                         r_state, w_state_nxt;
  logic [c_addr_nbits-1:0]        r_cnt;
  logic                           r_prio;
  logic [1:0]                     w_val, w_gnt;
  logic [1:0][c_addr_nbits-1:0]   w_addr;
  logic [1:0][p_data_nbits-1:0]   w_data;
  logic                           w_sel, w_xfer, w_in_range;
  logic [c_addr_nbits-1:0]        w_gaddr;
  logic [p_data_nbits-1:0]        w_gdata;

  assign w_val  = {req1_val, req0_val};
  assign w_addr = {req1_addr, req0_addr};
  assign w_data = {req1_data, req0_data};

  always_comb begin
    w_state_nxt = r_state;
    w_gnt       = '0;
    case (r_state)
      ST_INIT: if (r_cnt == c_last) w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (w_val == 2'b11) w_gnt[r_prio] = 1'b1;
        else                w_gnt = w_val;
      end
      default: w_state_nxt = ST_INIT;
    endcase
  end

  assign req0_rdy   = w_gnt[0];
  assign req1_rdy   = w_gnt[1];
  assign w_xfer     = |w_gnt;
  assign w_sel      = w_gnt[1];
  assign w_gaddr    = w_addr[w_sel];
  assign w_gdata    = w_data[w_sel];
  // Out-of-range writes still complete the handshake but never reach the rf.
  assign w_in_range = {1'b0, w_gaddr} < c_num;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
      r_prio  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_INIT) r_cnt  <= r_cnt + 1'b1;
      if (w_xfer)             r_prio <= ~w_sel;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rf_write_en   <= 1'b0;
      rf_write_addr <= '0;
      rf_write_data <= '0;
    end else if (r_state == ST_INIT) begin
      rf_write_en   <= 1'b1;
      rf_write_addr <= r_cnt;
      rf_write_data <= p_init_value;
    end else begin
      rf_write_en <= w_xfer && w_in_range;
      if (w_xfer && w_in_range) begin
        rf_write_addr <= w_gaddr;
        rf_write_data <= w_gdata;
      end
    end
  end

  assign init_done    = (r_state == ST_RUN);
  assign rf_read_addr = read_addr;

  // The registered write commits only at the next edge, so bypass it to readers.
  always_comb begin
    read_data = rf_read_data;
    if (r_state == ST_INIT)                                read_data = p_init_value;
    else if (rf_write_en && (rf_write_addr == read_addr)) read_data = rf_write_data;
  end

endmodule

// File: tb/tb_cmn_regfile_wr_sched.sv
// Bench for cmn_regfile_wr_sched: directed scenarios plus randomized traffic
// against a last-writer-wins register-file model.
module tb_cmn_regfile_wr_sched;
  localparam int N  = 5;
  localparam int DW = 16;
  localparam int AW = 3;
  localparam logic [DW-1:0] INIT = 16'h00A5;

  logic clk = 1'b0, reset = 1'b0;
  always #5 clk = ~clk;

  logic          req0_val = 1'b0, req1_val = 1'b0;
  logic [AW-1:0] req0_addr = '0, req1_addr = '0, read_addr = '0;
  logic [DW-1:0] req0_data = '0, req1_data = '0;
  logic          req0_rdy, req1_rdy, rf_write_en, init_done;
  logic [AW-1:0] rf_write_addr, rf_read_addr;
  logic [DW-1:0] rf_write_data, rf_read_data, read_data;

  int checks = 0, errors = 0;

  cmn_regfile_wr_sched #(.p_data_nbits(DW), .p_num_entries(N), .p_init_value(INIT)) dut (
    .clk(clk), .reset(reset),
    .req0_val(req0_val), .req0_rdy(req0_rdy), .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_val(req1_val), .req1_rdy(req1_rdy), .req1_addr(req1_addr), .req1_data(req1_data),
    .rf_write_en(rf_write_en), .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data),
    .read_addr(read_addr), .rf_read_addr(rf_read_addr), .rf_read_data(rf_read_data),
    .read_data(read_data), .init_done(init_done)
  );

  // Register-file instance stand-in; reset contents differ from INIT on purpose.
  logic [DW-1:0] mem [N];
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) mem[i] <= 16'hBEE0 + 16'(i);
    end else if (rf_write_en && int'(rf_write_addr) < N) begin
      mem[rf_write_addr] <= rf_write_data;
    end
  end
  assign rf_read_data = (int'(rf_read_addr) < N) ? mem[rf_read_addr] : '0;

  // Reference model: newest accepted value per entry, who was served last,
  // and what the write port should show after the most recent edge.
  bit            m_run;
  int            m_cnt;
  bit            m_prio;
  bit            e_wen;
  logic [AW-1:0] e_waddr;
  logic [DW-1:0] e_wdata;
  logic [DW-1:0] m_latest [N];

  task automatic m_reset();
    m_run = 0; m_cnt = 0; m_prio = 0;
    e_wen = 0; e_waddr = '0; e_wdata = '0;
    for (int i = 0; i < N; i++) m_latest[i] = INIT;
  endtask

  function automatic logic [1:0] f_gnt();
    if (!m_run) return 2'b00;
    if (req0_val && req1_val) return m_prio ? 2'b10 : 2'b01;
    return {req1_val, req0_val};
  endfunction

  function automatic logic [DW-1:0] f_rd();
    return m_run ? m_latest[read_addr] : INIT;
  endfunction

  task automatic mdl_edge();
    logic [1:0]    g;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    if (!m_run) begin
      e_wen = 1; e_waddr = AW'(m_cnt); e_wdata = INIT;
      m_cnt++;
      if (m_cnt == N) m_run = 1;
    end else begin
      g = f_gnt();
      e_wen = 0;
      if (g != 2'b00) begin
        a = g[1] ? req1_addr : req0_addr;
        d = g[1] ? req1_data : req0_data;
        m_prio = g[0];  // the other requester gets priority next time
        if (int'(a) < N) begin
          e_wen = 1; e_waddr = a; e_wdata = d; m_latest[a] = d;
        end
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    req0_val = 1; req1_val = 1;
    #1;
    checks++; if (rf_write_en !== 1'b0) begin errors++; $display("FAIL rst_wen: got %0h exp 0", rf_write_en); end
    checks++; if (rf_write_addr !== '0) begin errors++; $display("FAIL rst_waddr: got %0h exp 0", rf_write_addr); end
    checks++; if (rf_write_data !== '0) begin errors++; $display("FAIL rst_wdata: got %0h exp 0", rf_write_data); end
    checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL rst_init_done: got %0h exp 0", init_done); end
    checks++; if ({req1_rdy, req0_rdy} !== 2'b00) begin errors++; $display("FAIL rst_rdy: got %0b exp 00", {req1_rdy, req0_rdy}); end
    checks++; if (read_data !== INIT) begin errors++; $display("FAIL rst_read_data: got %0h exp %0h", read_data, INIT); end
    m_reset();
  endtask

  task automatic test_init_sweep();
    for (int k = 0; k <= N; k++) begin
      @(negedge clk);
      if (k == 0) reset = 1;
      req0_val = (k < N); req1_val = (k < N);
      read_addr = AW'($urandom_range(0, N-1));
      #1;
      checks++; if (init_done !== (k == N)) begin errors++; $display("FAIL init_done k=%0d: got %0h exp %0h", k, init_done, k == N); end
      if (k > 0) begin
        checks++;
        if (rf_write_en !== 1'b1 || rf_write_addr !== AW'(k-1) || rf_write_data !== INIT) begin
          errors++; $display("FAIL init_write k=%0d: got en=%0h a=%0h d=%0h exp en=1 a=%0h d=%0h",
                             k, rf_write_en, rf_write_addr, rf_write_data, k-1, INIT);
        end
      end
      if (k < N) begin
        checks++; if ({req1_rdy, req0_rdy} !== 2'b00) begin errors++; $display("FAIL init_rdy k=%0d: got %0b exp 00", k, {req1_rdy, req0_rdy}); end
        checks++; if (read_data !== INIT) begin errors++; $display("FAIL init_read k=%0d: got %0h exp %0h", k, read_data, INIT); end
      end
      mdl_edge();
    end
  endtask

  task automatic test_round_robin();
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      req0_val = (i < 4); req0_addr = 3'd1; req0_data = 16'h0011;
      req1_val = (i < 4); req1_addr = 3'd2; req1_data = 16'h0022;
      #1;
      if (i < 4) begin
        checks++;
        if (req0_rdy !== (i % 2 == 0) || req1_rdy !== (i % 2 == 1)) begin
          errors++; $display("FAIL rr_grant i=%0d: got %0b exp %0b", i, {req1_rdy, req0_rdy}, (i % 2 == 0) ? 2'b01 : 2'b10);
        end
      end
      if (i > 0) begin
        checks++;
        if (rf_write_en !== 1'b1 || rf_write_addr !== ((i % 2) ? 3'd1 : 3'd2) ||
            rf_write_data !== ((i % 2) ? 16'h0011 : 16'h0022)) begin
          errors++; $display("FAIL rr_write i=%0d: got en=%0h a=%0h d=%0h", i, rf_write_en, rf_write_addr, rf_write_data);
        end
      end
      mdl_edge();
    end
  endtask

  task automatic test_lone();
    logic [AW-1:0] pa;
    logic [DW-1:0] pd;
    pa = '0; pd = '0;
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      req0_val = (i == 3); req0_addr = 3'd0; req0_data = 16'h5A5A;
      req1_val = (i <= 3); req1_addr = AW'($urandom_range(0, N-1)); req1_data = DW'($urandom);
      #1;
      if (i < 3) begin
        checks++; if ({req1_rdy, req0_rdy} !== 2'b10) begin errors++; $display("FAIL lone_grant i=%0d: got %0b exp 10", i, {req1_rdy, req0_rdy}); end
      end else if (i == 3) begin
        checks++; if ({req1_rdy, req0_rdy} !== 2'b01) begin errors++; $display("FAIL lone_prio_after: got %0b exp 01", {req1_rdy, req0_rdy}); end
      end
      if (i > 0) begin
        checks++;
        if (rf_write_en !== 1'b1 || rf_write_addr !== pa || rf_write_data !== pd) begin
          errors++; $display("FAIL lone_write i=%0d: got en=%0h a=%0h d=%0h exp en=1 a=%0h d=%0h",
                             i, rf_write_en, rf_write_addr, rf_write_data, pa, pd);
        end
      end
      pa = (i == 3) ? req0_addr : req1_addr;
      pd = (i == 3) ? req0_data : req1_data;
      mdl_edge();
    end
  endtask

  task automatic test_forward();
    @(negedge clk);
    req0_val = 1; req0_addr = 3'd3; req0_data = 16'h1234; req1_val = 0; read_addr = 3'd3;
    #1;
    checks++; if (req0_rdy !== 1'b1) begin errors++; $display("FAIL fwd_rdy: got %0h exp 1", req0_rdy); end
    mdl_edge();
    @(negedge clk);
    req0_val = 0;
    #1;
    checks++; if (rf_write_en !== 1'b1 || rf_write_addr !== 3'd3) begin errors++; $display("FAIL fwd_write: got en=%0h a=%0h exp en=1 a=3", rf_write_en, rf_write_addr); end
    checks++; if (read_data !== 16'h1234) begin errors++; $display("FAIL fwd_bypass: got %0h exp 1234 (rf has %0h)", read_data, rf_read_data); end
    mdl_edge();
    @(negedge clk);
    #1;
    checks++; if (read_data !== rf_read_data) begin errors++; $display("FAIL fwd_after: got %0h exp rf %0h", read_data, rf_read_data); end
    checks++; if (read_data !== 16'h1234) begin errors++; $display("FAIL fwd_commit: got %0h exp 1234", read_data); end
    mdl_edge();
  endtask

  task automatic test_out_of_range();
    @(negedge clk);
    req1_val = 1; req1_addr = 3'd0; req1_data = 16'h0F0F; req0_val = 0;
    #1;
    checks++; if (req1_rdy !== 1'b1) begin errors++; $display("FAIL oor_pre_rdy: got %0h exp 1", req1_rdy); end
    mdl_edge();
    @(negedge clk);
    req1_val = 0; req0_val = 1; req0_addr = 3'd6; req0_data = 16'hDEAD;
    #1;
    checks++; if (req0_rdy !== 1'b1) begin errors++; $display("FAIL oor_rdy: got %0h exp 1", req0_rdy); end
    mdl_edge();
    @(negedge clk);
    req0_val = 1; req0_addr = 3'd1; req0_data = 16'h0101;
    req1_val = 1; req1_addr = 3'd2; req1_data = 16'h0202;
    #1;
    checks++; if (rf_write_en !== 1'b0) begin errors++; $display("FAIL oor_dropped: got en=%0h exp 0", rf_write_en); end
    checks++; if ({req1_rdy, req0_rdy} !== 2'b10) begin errors++; $display("FAIL oor_prio: got %0b exp 10", {req1_rdy, req0_rdy}); end
    mdl_edge();
    @(negedge clk);
    req0_val = 0; req1_val = 0;
    #1;
    checks++; if (rf_write_en !== 1'b1 || rf_write_addr !== 3'd2 || rf_write_data !== 16'h0202) begin
      errors++; $display("FAIL oor_next_write: got en=%0h a=%0h d=%0h exp 1/2/0202", rf_write_en, rf_write_addr, rf_write_data); end
    mdl_edge();
  endtask

  task automatic test_random(input int ncyc);
    bit         hold0, hold1;
    logic [1:0] g;
    hold0 = 0; hold1 = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (!hold0) begin
        req0_val = ($urandom_range(0, 3) != 0); req0_addr = AW'($urandom_range(0, 7)); req0_data = DW'($urandom);
      end
      if (!hold1) begin
        req1_val = ($urandom_range(0, 3) != 0); req1_addr = AW'($urandom_range(0, 7)); req1_data = DW'($urandom);
      end
      read_addr = AW'($urandom_range(0, N-1));
      #1;
      g = f_gnt();
      checks++; if ({req1_rdy, req0_rdy} !== g) begin errors++; $display("FAIL rnd_rdy c=%0d: got %0b exp %0b", c, {req1_rdy, req0_rdy}, g); end
      checks++; if (rf_write_en !== e_wen) begin errors++; $display("FAIL rnd_wen c=%0d: got %0h exp %0h", c, rf_write_en, e_wen); end
      if (e_wen) begin
        checks++; if (rf_write_addr !== e_waddr || rf_write_data !== e_wdata) begin
          errors++; $display("FAIL rnd_write c=%0d: got a=%0h d=%0h exp a=%0h d=%0h", c, rf_write_addr, rf_write_data, e_waddr, e_wdata); end
      end
      checks++; if (read_data !== f_rd()) begin errors++; $display("FAIL rnd_read c=%0d a=%0h: got %0h exp %0h", c, read_addr, read_data, f_rd()); end
      checks++; if (init_done !== m_run) begin errors++; $display("FAIL rnd_init_done c=%0d: got %0h exp %0h", c, init_done, m_run); end
      hold0 = req0_val && !g[0];
      hold1 = req1_val && !g[1];
      mdl_edge();
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    found = 0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      req0_val = 1; req0_addr = 3'd1; req0_data = 16'h7777;
      req1_val = 1; req1_addr = 3'd2; req1_data = 16'h8888;
      #1;
      if (rf_write_en) found = 1;
      else mdl_edge();
    end
    checks++; if (!found) begin errors++; $display("FAIL mid_wait: got no write within 10 cycles, exp a write"); end
    reset = 0;
    #1;
    checks++; if (rf_write_en !== 1'b0) begin errors++; $display("FAIL mid_wen: got %0h exp 0", rf_write_en); end
    checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL mid_init_done: got %0h exp 0", init_done); end
    checks++; if ({req1_rdy, req0_rdy} !== 2'b00) begin errors++; $display("FAIL mid_rdy: got %0b exp 00", {req1_rdy, req0_rdy}); end
    checks++; if (rf_write_addr !== '0 || rf_write_data !== '0) begin errors++; $display("FAIL mid_wregs: got a=%0h d=%0h exp 0/0", rf_write_addr, rf_write_data); end
    m_reset();
    for (int k = 0; k <= N; k++) begin
      @(negedge clk);
      if (k == 0) reset = 1;
      req0_val = 0; req1_val = 0;
      #1;
      if (k > 0) begin
        checks++; if (rf_write_en !== 1'b1 || rf_write_addr !== AW'(k-1) || rf_write_data !== INIT) begin
          errors++; $display("FAIL mid_resweep k=%0d: got en=%0h a=%0h d=%0h exp en=1 a=%0h", k, rf_write_en, rf_write_addr, rf_write_data, k-1); end
      end
      checks++; if (init_done !== (k == N)) begin errors++; $display("FAIL mid_init_done k=%0d: got %0h exp %0h", k, init_done, k == N); end
      mdl_edge();
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_init_sweep();
    test_round_robin();
    test_lone();
    test_forward();
    test_out_of_range();
    test_random(400);
    test_reset_mid();
    test_random(200);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, exp completion");
    $fatal(1, "watchdog");
  end
endmodule
